fifo_lvl: RTL and testbench

Parametrised synchronous FIFO for the UART TX/RX data paths. It replaces the flag-only FIFO with an occupancy counter, programmable almost-full/almost-empty flags and a synchronous flush. It also defines read/write behaviour at the full and empty boundaries. It sits between the baud-tick UART engines and the host-side register interface.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 21 ++
 rtl/fifo_lvl.sv | 88 ++++++++
 tb/tb_fifo_lvl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers and threshold legality check shared by the fifo_lvl slice
package fifo_pkg;

    function automatic int depth(input int w);
        return 1 << w;
    endfunction

    function automatic int cnt_w(input int w);
        return w + 1;
    endfunction

    function automatic bit thr_ok(input int w, input int af, input int ae);
        return af >= 1 && af <= depth(w) && ae >= 0 && ae <= depth(w) - 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: B x 2**W register array, synchronous write, asynchronous read (no reset on storage)
module fifo_ram #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    logic [B-1:0] r_mem [2**W];

    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: show-ahead synchronous FIFO with occupancy count, almost flags and sync flush.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with clr_err.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_THR = 2**W - 2,
    parameter int AE_THR = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
`endif
);

    localparam int CW = cnt_w(W);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth(W));
    localparam logic [CW-1:0] AF_C    = CW'(AF_THR);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THR);

    if (!thr_ok(W, AF_THR, AE_THR)) begin : g_bad_thr
        $error("fifo_lvl: AF_THR must be 1..DEPTH and AE_THR 0..DEPTH-1");
    end

    logic [W-1:0]  r_wptr, r_rptr;
    logic          w_wr_en, w_rd_en;
    logic [CW-1:0] w_cnt_nxt;

    // a write into a full FIFO is allowed only when the same edge frees the head slot
    assign w_rd_en   = rd & ~empty;
    assign w_wr_en   = wr & (~full | w_rd_en);
    assign w_cnt_nxt = count + CW'(w_wr_en) - CW'(w_rd_en);

    fifo_ram #(.B(B), .W(W)) u_ram (
        .clk   (clk),
        .we    (w_wr_en & ~flush),
        .waddr (r_wptr),
        .wdata (w_data),
        .raddr (r_rptr),
        .rdata (r_data)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst || flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_THR == 0);
            almost_empty <= 1'b1;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + W'(1);
            if (w_rd_en) r_rptr <= r_rptr + W'(1);
            count        <= w_cnt_nxt;
            full         <= w_cnt_nxt == DEPTH_C;
            empty        <= w_cnt_nxt == '0;
            almost_full  <= w_cnt_nxt >= AF_C;
            almost_empty <= w_cnt_nxt <= AE_C;
        end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst || flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & full & ~w_rd_en) | (overflow & ~clr_err);
            underflow <= (rd & empty) | (underflow & ~clr_err);
        end
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: vector table, directed corner sequences and random traffic against a queue model
module tb_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
    logic       clr_err = 1'b0;
    bit         m_ov = 0, m_un = 0;
`endif

    fifo_lvl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    logic [7:0] q[$];
    bit         last_we;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: FIFO contents as a queue; acceptance decided from occupancy before the edge
    task automatic drive(input bit w, input bit r, input bit f, input logic [7:0] d, input bit c);
        int sz = q.size();
        bit re = r && sz > 0;
        bit we = w && (sz < 16 || re);
        wr = w; rd = r; flush = f; w_data = d;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = c;
        if (f) begin m_ov = 0; m_un = 0; end
        else begin
            m_ov = (w && sz == 16 && !re) || (m_ov && !c);
            m_un = (r && sz == 0) || (m_un && !c);
        end
`endif
        last_we = 0;
        if (f) q.delete();
        else begin
            if (re) void'(q.pop_front());
            if (we) q.push_back(d);
            last_we = we;
        end
        @(posedge clk);
        #1;
        wr = 0; rd = 0; flush = 0;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = 0;
`endif
    endtask

    task automatic check_model();
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(q.size() == 16));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("almost_full", int'(almost_full), int'(q.size() >= 14));
        chk("almost_empty", int'(almost_empty), int'(q.size() <= 1));
        if (q.size() > 0) chk("r_data", int'(r_data), int'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", int'(overflow), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_un));
`endif
    endtask

    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        drive(w, r, 0, d, 0);
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_ae"}, int'(almost_empty), 1);
    endtask

    typedef struct {
        bit         w, r, f;
        logic [7:0] d;
        int         cnt;
        bit         fu, em, af, ae, has_rd;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 1, 8'h11};
        tbl[1] = '{1, 1, 0, 8'h22, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[2] = '{1, 0, 0, 8'h33, 2, 0, 0, 0, 0, 1, 8'h22};
        tbl[3] = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h33};
        tbl[4] = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[5] = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[6] = '{1, 1, 0, 8'hA5, 1, 0, 0, 0, 1, 1, 8'hA5};
        tbl[7] = '{1, 0, 1, 8'h77, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[8] = '{1, 0, 0, 8'h44, 1, 0, 0, 0, 1, 1, 8'h44};
        tbl[9] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00};

        #12;
        check_reset_outputs("reset");
        #6 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].d, 0);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].fu));
            chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].em));
            chk($sformatf("tbl%0d_af", i), int'(almost_full), int'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), int'(almost_empty), int'(tbl[i].ae));
            if (tbl[i].has_rd) chk($sformatf("tbl%0d_rdata", i), int'(r_data), int'(tbl[i].rdat));
        end

        // fill to full, then one refused write
        for (int k = 1; k <= 16; k++) begin
            cycle(1, 0, 8'(k));
            chk("fill_count", int'(count), k);
            chk("fill_af", int'(almost_full), int'(k >= 14));
        end
        chk("fill_full", int'(full), 1);
        cycle(1, 0, 8'hFF);
        chk("ovf_count", int'(count), 16);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag", int'(overflow), 1);
`endif

        // drain in order, then one refused read
        for (int k = 1; k <= 16; k++) begin
            chk("drain_rdata", int'(r_data), k);
            cycle(0, 1, 8'h00);
        end
        chk("drain_empty", int'(empty), 1);
        cycle(0, 1, 8'h00);
        chk("udf_count", int'(count), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_flag", int'(underflow), 1);
        drive(0, 0, 0, 8'h00, 1);
        check_model();
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_udf", int'(underflow), 0);
        drive(0, 1, 0, 8'h00, 1);
        check_model();
        chk("clr_vs_set", int'(underflow), 1);
        drive(0, 0, 0, 8'h00, 1);
`endif

        // simultaneous read and write on an empty FIFO: only the write lands
        cycle(1, 1, 8'hA5);
        chk("wr_rd_empty_count", int'(count), 1);
        chk("wr_rd_empty_rdata", int'(r_data), 8'hA5);
        cycle(0, 1, 8'h00);

        // simultaneous read and write on a full FIFO for 16 cycles
        for (int k = 1; k <= 16; k++) cycle(1, 0, 8'(8'h80 + k));
        for (int k = 1; k <= 16; k++) begin
            chk("full_wr_rd_head", int'(r_data), 8'h80 + k);
            cycle(1, 1, 8'h5A);
            chk("full_wr_rd_count", int'(count), 16);
        end
        chk("full_wr_rd_tail", int'(r_data), 8'h5A);
        drive(0, 0, 1, 8'h00, 0);
        check_model();

        // 40 writes with a read every other cycle, wrapping the pointers
        begin
            int nw = 0;
            for (int c = 0; c < 400 && nw < 40; c++) begin
                cycle(1, c % 2 == 1, 8'(nw + 100));
                if (last_we) nw++;
            end
            chk("wrap_writes_done", nw, 40);
            for (int c = 0; c < 40 && q.size() > 0; c++) cycle(0, 1, 8'h00);
            chk("wrap_drained", int'(count), 0);
        end

        // random traffic, occasional flush
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 1'($urandom), $urandom_range(0, 40) == 0, 8'($urandom), 0);
            check_model();
        end

        // flush with a concurrent write at count 9
        drive(0, 0, 1, 8'h00, 0);
        for (int k = 0; k < 9; k++) cycle(1, 0, 8'(8'h30 + k));
        chk("pre_flush_count", int'(count), 9);
        drive(1, 0, 1, 8'hEE, 0);
        check_model();
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);

        // asynchronous reset in the middle of a write burst
        for (int k = 0; k < 5; k++) cycle(1, 0, 8'(8'h50 + k));
        wr = 1; w_data = 8'h99;
        #3 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 check_reset_outputs("rst_held");
        wr = 0;
        rst = 1'b1;
        q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        m_ov = 0; m_un = 0;
`endif
        cycle(1, 0, 8'h66);
        chk("post_rst_rdata", int'(r_data), 8'h66);
        cycle(1, 0, 8'h67);
        cycle(0, 1, 8'h00);
        chk("post_rst_second", int'(r_data), 8'h67);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
